// File: rtl/native_ram.sv
// native_ram
// ----------
// Word-addressed memory served over a native valid/ready bus with four
// independent channels: read address, read data, write address and write data.
// Reads pass through a fixed-latency pipeline into an in-order response FIFO.
// This lets several reads be outstanding while rdata is back-pressured.
// Write address and write data may arrive on different cycles; each waits in a
// one-entry holding register until its partner shows up.
//
// Parameters:
//   bus_width      address and data width
//   depth_log2     log2 of the number of storage words
//   read_latency   cycles from raddr handshake to response entering the FIFO (1..8)
//   rd_outstanding reads accepted but not yet consumed on rdata (1..16)
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   raddr_valid/ready, raddr   read address channel (byte address)
//   rdata_valid/ready, rdata   read response channel
//   waddr_valid/ready, waddr   write address channel (byte address)
//   wdata_valid/ready, wdata   write data channel
module native_ram #(
  parameter int bus_width      = 32,
  parameter int depth_log2     = 10,
  parameter int read_latency   = 1,
  parameter int rd_outstanding = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raddr_valid,
  output logic                 raddr_ready,
  input  logic [bus_width-1:0] raddr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic [bus_width-1:0] rdata,
  input  logic                 waddr_valid,
  output logic                 waddr_ready,
  input  logic [bus_width-1:0] waddr,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [bus_width-1:0] wdata
);

  localparam int words = 1 << depth_log2;
  localparam int cnt_w = $clog2(rd_outstanding + 1);
  localparam int ptr_w = (rd_outstanding > 1) ? $clog2(rd_outstanding) : 1;

  logic [bus_width-1:0] mem [words];

  // Handshakes on each channel
  logic raddr_hs, rdata_hs, waddr_hs, wdata_hs;
  assign raddr_hs = raddr_valid && raddr_ready;
  assign rdata_hs = rdata_valid && rdata_ready;
  assign waddr_hs = waddr_valid && waddr_ready;
  assign wdata_hs = wdata_valid && wdata_ready;

  // Word indices; the byte-offset bits and the bits above the memory size are dropped,
  // so addresses alias modulo the memory size
  logic [depth_log2-1:0] raddr_idx, waddr_idx;
  assign raddr_idx = raddr[depth_log2+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[1:0], waddr[1:0],
                              raddr >> (depth_log2 + 2), waddr >> (depth_log2 + 2)};

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // Outstanding-read counter. It covers reads still in the pipeline as well as
  // reads waiting in the FIFO, so the FIFO can never overflow.
  logic [cnt_w-1:0] cnt;
  assign raddr_ready = !rst && (cnt < cnt_w'(rd_outstanding));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (raddr_hs && !rdata_hs) begin
      cnt <= cnt + 1'b1;
    end else if (!raddr_hs && rdata_hs) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Latency pipeline valids; stage 0 is loaded on the raddr handshake edge
  logic [read_latency-1:0] pipe_valid;
  logic [bus_width-1:0]    pipe_data [read_latency];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= raddr_hs;
      for (int i = 1; i < read_latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Response FIFO control
  logic                 push;
  logic [ptr_w-1:0]     wr_ptr, rd_ptr;
  logic [cnt_w-1:0]     fifo_count;
  logic [bus_width-1:0] fifo_mem [rd_outstanding];

  assign push = pipe_valid[read_latency-1];

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(rd_outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rdata_hs) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !rdata_hs) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && rdata_hs) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  assign rdata_valid = (fifo_count != '0);
  assign rdata       = rdata_valid ? fifo_mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------

  // One-entry holding registers let address and data arrive on different cycles
  logic                 a_held, d_held;
  logic [bus_width-1:0] held_addr, held_data;
  logic [bus_width-1:0] eff_addr, eff_data;
  logic                 wr_en;

  assign waddr_ready = !rst && !a_held;
  assign wdata_ready = !rst && !d_held;
  assign eff_addr    = a_held ? held_addr : waddr;
  assign eff_data    = d_held ? held_data : wdata;
  assign wr_en       = (a_held || waddr_hs) && (d_held || wdata_hs);
  assign waddr_idx   = eff_addr[depth_log2+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_held    <= 1'b0;
      d_held    <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
    end else if (wr_en) begin
      a_held <= 1'b0;
      d_held <= 1'b0;
    end else begin
      if (waddr_hs) begin
        a_held    <= 1'b1;
        held_addr <= waddr;
      end
      if (wdata_hs) begin
        d_held    <= 1'b1;
        held_data <= wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: memory, pipeline data and FIFO entries are not reset
  // ---------------------------------------------------------------------------

  // The read of mem and the write to mem share an edge. A read therefore sees
  // the old word when a write to the same word commits on that edge.
  always_ff @(posedge clk) begin
    if (raddr_hs) begin
      pipe_data[0] <= mem[raddr_idx];
    end
    for (int i = 1; i < read_latency; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
    if (wr_en) begin
      mem[waddr_idx] <= eff_data;
    end
    if (push) begin
      fifo_mem[wr_ptr] <= pipe_data[read_latency-1];
    end
  end

endmodule

// File: tb/tb_native_ram.sv
// tb_native_ram
// -------------
// Directed bench for native_ram. It drives two instances side by side:
// fast_ram has read_latency 1 and slow_ram has read_latency 3.
// Both instances have rd_outstanding 4 and depth_log2 10.
module tb_native_ram;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // fast instance signals
  logic        f_raddr_valid, f_raddr_ready, f_rdata_valid, f_rdata_ready;
  logic        f_waddr_valid, f_waddr_ready, f_wdata_valid, f_wdata_ready;
  logic [31:0] f_raddr, f_rdata, f_waddr, f_wdata;

  // slow instance signals
  logic        s_raddr_valid, s_raddr_ready, s_rdata_valid, s_rdata_ready;
  logic        s_waddr_valid, s_waddr_ready, s_wdata_valid, s_wdata_ready;
  logic [31:0] s_raddr, s_rdata, s_waddr, s_wdata;

  int          test_count = 0;
  int          fail_count = 0;
  int          got;
  logic [31:0] exp_vals [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};

  native_ram #(.bus_width(32), .depth_log2(10), .read_latency(1), .rd_outstanding(4)) fast_ram (
    .clk(clk), .rst(rst),
    .raddr_valid(f_raddr_valid), .raddr_ready(f_raddr_ready), .raddr(f_raddr),
    .rdata_valid(f_rdata_valid), .rdata_ready(f_rdata_ready), .rdata(f_rdata),
    .waddr_valid(f_waddr_valid), .waddr_ready(f_waddr_ready), .waddr(f_waddr),
    .wdata_valid(f_wdata_valid), .wdata_ready(f_wdata_ready), .wdata(f_wdata)
  );

  native_ram #(.bus_width(32), .depth_log2(10), .read_latency(3), .rd_outstanding(4)) slow_ram (
    .clk(clk), .rst(rst),
    .raddr_valid(s_raddr_valid), .raddr_ready(s_raddr_ready), .raddr(s_raddr),
    .rdata_valid(s_rdata_valid), .rdata_ready(s_rdata_ready), .rdata(s_rdata),
    .waddr_valid(s_waddr_valid), .waddr_ready(s_waddr_ready), .waddr(s_waddr),
    .wdata_valid(s_wdata_valid), .wdata_ready(s_wdata_ready), .wdata(s_wdata)
  );

  // Advance one clock and settle just after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive every input of the fast instance at once
  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic rr,
                               input logic wav, input logic [31:0] wa,
                               input logic wdv, input logic [31:0] wd);
    f_raddr_valid = rv;
    f_raddr       = ra;
    f_rdata_ready = rr;
    f_waddr_valid = wav;
    f_waddr       = wa;
    f_wdata_valid = wdv;
    f_wdata       = wd;
  endtask

  // Drive every input of the slow instance at once
  task automatic applySlow(input logic rv, input logic [31:0] ra, input logic rr,
                           input logic wav, input logic [31:0] wa,
                           input logic wdv, input logic [31:0] wd);
    s_raddr_valid = rv;
    s_raddr       = ra;
    s_rdata_ready = rr;
    s_waddr_valid = wav;
    s_waddr       = wa;
    s_wdata_valid = wdv;
    s_wdata       = wd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with every valid asserted
    rst = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h55);
    applySlow(1'b1, 32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h55);
    tick; tick; tick;
    checkOutput("rst_raddr_ready", {31'b0, f_raddr_ready}, 32'd0);
    checkOutput("rst_waddr_ready", {31'b0, f_waddr_ready}, 32'd0);
    checkOutput("rst_wdata_ready", {31'b0, f_wdata_ready}, 32'd0);
    checkOutput("rst_rdata_valid", {31'b0, f_rdata_valid}, 32'd0);
    checkOutput("rst_rdata", f_rdata, 32'd0);
    checkOutput("rst_slow_valid", {31'b0, s_rdata_valid}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    checkOutput("post_rst_raddr_ready", {31'b0, f_raddr_ready}, 32'd1);
    checkOutput("post_rst_waddr_ready", {31'b0, f_waddr_ready}, 32'd1);
    checkOutput("post_rst_wdata_ready", {31'b0, f_wdata_ready}, 32'd1);
    checkOutput("post_rst_rdata_valid", {31'b0, f_rdata_valid}, 32'd0);

    // Write then read at latency 1
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF);
    tick;
    checkOutput("wr_waddr_ready", {31'b0, f_waddr_ready}, 32'd1);
    checkOutput("wr_wdata_ready", {31'b0, f_wdata_ready}, 32'd1);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("lat1_early_valid", {31'b0, f_rdata_valid}, 32'd0);
    tick;
    checkOutput("lat1_valid", {31'b0, f_rdata_valid}, 32'd1);
    checkOutput("lat1_data", f_rdata, 32'hDEADBEEF);
    tick;
    checkOutput("lat1_drained", {31'b0, f_rdata_valid}, 32'd0);

    // Write then read at latency 3; also preload 0x44 for the reset test
    applySlow(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hCAFEF00D);
    tick;
    applySlow(1'b0, 32'h0, 1'b1, 1'b1, 32'h44, 1'b1, 32'h77);
    tick;
    applySlow(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("lat3_wait", {31'b0, s_rdata_valid}, 32'd0);
      tick;
    end
    checkOutput("lat3_valid", {31'b0, s_rdata_valid}, 32'd1);
    checkOutput("lat3_data", s_rdata, 32'hCAFEF00D);
    tick;
    checkOutput("lat3_drained", {31'b0, s_rdata_valid}, 32'd0);

    // Split write: address first, data three cycles later
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("split_c1_waddr_ready", {31'b0, f_waddr_ready}, 32'd0);
    checkOutput("split_c1_wdata_ready", {31'b0, f_wdata_ready}, 32'd1);
    tick;
    checkOutput("split_c2_waddr_ready", {31'b0, f_waddr_ready}, 32'd0);
    tick;
    checkOutput("split_c3_waddr_ready", {31'b0, f_waddr_ready}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h12345678);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("split_c4_waddr_ready", {31'b0, f_waddr_ready}, 32'd1);
    checkOutput("split_c4_wdata_ready", {31'b0, f_wdata_ready}, 32'd1);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    checkOutput("split_read_valid", {31'b0, f_rdata_valid}, 32'd1);
    checkOutput("split_read_data", f_rdata, 32'h12345678);
    tick;

    // Backpressure: preload words 0..4 with 1..5, then read with rdata stalled
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'(4 * i), 1'b1, 32'(i + 1));
      tick;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      f_raddr_valid = 1'b1;
      f_raddr       = 32'(4 * i);
      checkOutput("bp_accept_ready", {31'b0, f_raddr_ready}, 32'd1);
      tick;
    end
    f_raddr = 32'h10;
    checkOutput("bp_full_ready", {31'b0, f_raddr_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("bp_stall_ready", {31'b0, f_raddr_ready}, 32'd0);
      checkOutput("bp_stall_valid", {31'b0, f_rdata_valid}, 32'd1);
      checkOutput("bp_stall_data", f_rdata, 32'd1);
    end
    f_rdata_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (f_rdata_valid) begin
        checkOutput("bp_order", f_rdata, exp_vals[got]);
        got++;
      end
      if (f_raddr_valid && f_raddr_ready) begin
        tick;
        f_raddr_valid = 1'b0;
      end else begin
        tick;
      end
    end
    checkOutput("bp_count", 32'(got), 32'd5);
    checkOutput("bp_drained", {31'b0, f_rdata_valid}, 32'd0);

    // Collision: read and write of the same word on one edge, then aliasing
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, 32'hA);
    tick;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'hB);
    tick;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("coll_old_valid", {31'b0, f_rdata_valid}, 32'd1);
    checkOutput("coll_old_data", f_rdata, 32'hA);
    tick;
    checkOutput("coll_new_data", f_rdata, 32'hB);
    tick;
    applyStimulus(1'b1, 32'h1040, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    checkOutput("alias_valid", {31'b0, f_rdata_valid}, 32'd1);
    checkOutput("alias_data", f_rdata, 32'hB);
    tick;

    // Reset mid-operation on the slow instance
    applySlow(1'b1, 32'h10, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    tick;
    applySlow(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", {31'b0, s_rdata_valid}, 32'd0);
    checkOutput("midrst_raddr_ready", {31'b0, s_raddr_ready}, 32'd0);
    tick;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("midrst_no_response", {31'b0, s_rdata_valid}, 32'd0);
      tick;
    end
    checkOutput("midrst_wdata_ready", {31'b0, s_wdata_ready}, 32'd1);
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h99);
    tick;
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("midrst_wdata_held", {31'b0, s_wdata_ready}, 32'd0);
    applySlow(1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    applySlow(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick; tick; tick;
    checkOutput("midrst_readback_valid", {31'b0, s_rdata_valid}, 32'd1);
    checkOutput("midrst_readback_data", s_rdata, 32'h77);
    tick;

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/native_ram.md
Name: native_ram

Overview:
- Parametrised, synthesizable successor to the native-bus memory model.
- Serves one native valid/ready port set with four independent channels: raddr, rdata, waddr, wdata.
- Adds configurable read latency, multiple outstanding reads with a response FIFO, rdata backpressure, and independent waddr/wdata arrival pairing.
- Instantiated once for the instruction port and once for the data port of copperv, in simulation and in FPGA builds.

Parameters:
- bus_width, 32: address and data width.
- depth_log2, 10: log2 of the number of words of storage.
- read_latency, 1: cycles from raddr handshake to data entering the response FIFO; legal values are 1 to 8.
- rd_outstanding, 4: maximum reads accepted but not yet consumed on rdata; legal values are 1 to 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- raddr_valid  input  1  read address valid.
- raddr_ready  output  1  read address can be accepted.
- raddr  input  bus_width  byte read address.
- rdata_valid  output  1  read response valid.
- rdata_ready  input  1  read response accepted.
- rdata  output  bus_width  read response data.
- waddr_valid  input  1  write address valid.
- waddr_ready  output  1  write address can be accepted.
- waddr  input  bus_width  byte write address.
- wdata_valid  input  1  write data valid.
- wdata_ready  output  1  write data can be accepted.
- wdata  input  bus_width  write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
- Addressing: word index = addr[depth_log2+1:2]. Bits [1:0] are ignored. Bits above depth_log2+1 are ignored, so addresses alias modulo the memory size.
- Reset, while rst=1:
  - raddr_ready, waddr_ready, wdata_ready, rdata_valid are 0; rdata is 0.
  - The latency pipeline valids, FIFO pointers, outstanding count and write holding registers are all cleared.
  - Memory contents are not reset; a read before any write returns undefined data.
  - Readies rise in the first cycle after rst falls.
- Read path:
  - An outstanding counter cnt (0 to rd_outstanding) increments on each raddr handshake and decrements on each rdata handshake. If both happen on the same edge, cnt is unchanged.
  - raddr_ready = !rst && (cnt < rd_outstanding).
  - On a raddr handshake at edge E, the memory word is sampled at E and enters a read_latency-stage valid/data shift pipeline. It is pushed into the response FIFO at edge E+read_latency, so rdata_valid can first be 1 in the cycle after that edge.
  - The response FIFO has rd_outstanding entries. rdata_valid = FIFO not empty; rdata = FIFO head.
  - Because cnt gates acceptance, the FIFO never overflows; no drop or overflow path exists.
  - rdata and rdata_valid hold stable while rdata_valid && !rdata_ready.
  - Responses return strictly in request order. Peak throughput is 1 read per cycle.
- Write path:
  - waddr and wdata each have a one-entry holding register with a flag (a_held, d_held).
  - waddr_ready = !rst && !a_held; wdata_ready = !rst && !d_held.
  - At each edge: eff_addr = the held address, else the address arriving on this edge's handshake. eff_data is formed the same way.
  - If both eff_addr and eff_data exist, the memory word is written and both held flags are cleared.
  - Otherwise, whichever half arrived is stored and its held flag is set.
  - Address and data presented together on the same edge write in that cycle, giving 1 write per cycle.
- Read/write collision: a read accepted on the same edge as a write to the same word returns the old data (read-before-write). A read accepted on any later edge returns the new data.
- Reset mid-operation: in-flight and queued read responses are discarded and never appear on rdata. A half-received write is discarded. Writes already committed remain in memory.

Test Plan:
1. Reset: hold rst=1 for 3 cycles while driving all valids=1 → all readies and rdata_valid are 0, and no memory change. One cycle after rst falls, raddr_ready=waddr_ready=wdata_ready=1.
2. Write then read, read_latency=1: same-cycle waddr=0x10 and wdata=0xDEADBEEF, then raddr=0x10 with rdata_ready=1 → rdata_valid=1 exactly one cycle after the raddr handshake, with rdata=0xDEADBEEF. Repeat with read_latency=3 → rdata_valid delayed by 3.
3. Split write: waddr=0x20 handshake at cycle 0, wdata=0x12345678 at cycle 3 → waddr_ready=0 in cycles 1–3; the write commits at cycle 3; both readies are 1 at cycle 4. A readback of 0x20 returns 0x12345678.
4. Backpressure, rd_outstanding=4, rdata_ready=0: issue reads to 0x0, 0x4, 0x8, 0xC, 0x10 back-to-back (preloaded with 1, 2, 3, 4, 5) → 4 handshakes, then raddr_ready=0 with the 5th held. Raise rdata_ready → 1, 2, 3, 4, 5 are returned in order, and rdata stays stable throughout the stall.
5. Collision and aliasing: word 0x40 holds 0xA; a write of 0xB to 0x40 and a read of 0x40 on the same edge → read returns 0xA and the next read returns 0xB. With depth_log2=10, a read of 0x1040 returns 0xB.
6. Reset mid-op: read_latency=3, two reads in flight, plus a waddr-only handshake; assert rst for 1 cycle → rdata_valid never goes to 1 for those reads, and a subsequent wdata alone does not write.
